// File: rtl/modbus_converter_if.sv
// APB3 bus bundle for the Modbus converter register block.
// The slave modport is the converter's view; the master modport is the host's.
interface modbus_converter_if;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/modbus_converter.sv
// PLC I/O converter: APB3 register block with GPIO, timer, IRQ status,
// a 4-entry scan table and an 8N1 UART byte transmitter/receiver.
module modbus_converter (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  modbus_converter_if.slave        apb,
  input  logic                     UART_RX,
  output logic                     UART_TX,
  input  logic [31:0]              GPIO_DI,
  output logic [31:0]              GPIO_DO
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  localparam logic [3:0] OFF_DO        = 4'h0;
  localparam logic [3:0] OFF_DI        = 4'h1;
  localparam logic [3:0] OFF_TIMER     = 4'h2;
  localparam logic [3:0] OFF_MSG       = 4'h3;
  localparam logic [3:0] OFF_CFG0      = 4'h4;
  localparam logic [3:0] OFF_CFG1      = 4'h5;
  localparam logic [3:0] OFF_MAP       = 4'h6;
  localparam logic [3:0] OFF_IRQ       = 4'h7;
  localparam logic [3:0] OFF_SCAN_CTRL = 4'h8;
  localparam logic [3:0] OFF_SCAN_IDX  = 4'hA;
  localparam logic [3:0] OFF_ENTRY     = 4'hB;
  localparam logic [3:0] OFF_QTY       = 4'hC;
  localparam logic [3:0] OFF_WBASE     = 4'hD;
  localparam logic [3:0] OFF_RBASE     = 4'hE;

  localparam logic [31:0] CFG0_RST      = 32'h0001_0000;
  localparam logic [31:0] CFG1_RST      = 32'h0080_0036;
  localparam logic [31:0] SCAN_CTRL_RST = 32'h0001_0014;
  localparam logic [31:0] ENTRY_RST     = 32'h0001_0400;
  localparam logic [31:0] QTY_RST       = 32'h0010_0010;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // Register state
  logic [31:0] do_q, do_d, timer_q, timer_d, cfg0_q, cfg0_d, cfg1_q, cfg1_d;
  logic [31:0] map_q, map_d, scan_ctrl_q, scan_ctrl_d;
  logic [1:0]  irq_q, irq_d, scan_idx_q, scan_idx_d;
  logic [31:0] di_s1_q, di_s2_q;
  logic [31:0] scan_entry_q [4], scan_entry_d [4];
  logic [31:0] scan_qty_q   [4], scan_qty_d   [4];
  logic [31:0] scan_wbase_q [4], scan_wbase_d [4];
  logic [31:0] scan_rbase_q [4], scan_rbase_d [4];

  // UART state
  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [19:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]  hold_byte_q, hold_byte_d, rx_byte_q, rx_byte_d;
  logic        hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic        tx_line_q, tx_line_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_done;
  logic        stat_tx_empty;

  logic [3:0]  off;
  logic        wr_en, rd_access, msg_wr, msg_rd;
  logic [15:0] d_eff;
  logic [19:0] bit_last, half_last;
  logic        unused_addr_bits;

  assign off              = apb.PADDR[5:2];
  assign unused_addr_bits = ^{apb.PADDR[11:6], apb.PADDR[1:0]};
  assign wr_en            = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_access        = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign msg_wr           = wr_en && (off == OFF_MSG) && apb.PSTRB[0];
  assign msg_rd           = rd_access && (off == OFF_MSG);

  assign d_eff     = (cfg1_q[15:0] == 16'd0) ? 16'd1 : cfg1_q[15:0];
  assign bit_last  = {d_eff, 4'b0000} - 20'd1;
  assign half_last = {1'b0, d_eff, 3'b000} - 20'd1;

  assign stat_tx_empty = ~hold_full_q && (tx_state_q == ST_IDLE);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign GPIO_DO     = do_q;
  assign UART_TX     = tx_line_q;

  // Register file next-state
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    do_d         = do_q;
    timer_d      = timer_q + 32'd1;
    cfg0_d       = cfg0_q;
    cfg1_d       = cfg1_q;
    map_d        = map_q;
    scan_ctrl_d  = scan_ctrl_q;
    scan_idx_d   = scan_idx_q;
    scan_entry_d = scan_entry_q;
    scan_qty_d   = scan_qty_q;
    scan_wbase_d = scan_wbase_q;
    scan_rbase_d = scan_rbase_q;
    irq_d        = irq_q;
    if (wr_en) begin
      case (off)
        OFF_DO:        do_d        = merge_bytes(do_q, apb.PWDATA, apb.PSTRB);
        OFF_TIMER:     timer_d     = merge_bytes(timer_q, apb.PWDATA, apb.PSTRB);
        OFF_CFG0:      cfg0_d      = merge_bytes(cfg0_q, apb.PWDATA, apb.PSTRB);
        OFF_CFG1:      cfg1_d      = merge_bytes(cfg1_q, apb.PWDATA, apb.PSTRB);
        OFF_MAP:       map_d       = merge_bytes(map_q, apb.PWDATA, apb.PSTRB);
        OFF_IRQ:       if (apb.PSTRB[0]) irq_d = irq_q & ~apb.PWDATA[1:0];
        OFF_SCAN_CTRL: scan_ctrl_d = merge_bytes(scan_ctrl_q, apb.PWDATA, apb.PSTRB);
        OFF_SCAN_IDX:  if (apb.PSTRB[0]) scan_idx_d = apb.PWDATA[1:0];
        OFF_ENTRY:     scan_entry_d[scan_idx_q] =
                         merge_bytes(scan_entry_q[scan_idx_q], apb.PWDATA, apb.PSTRB);
        OFF_QTY:       scan_qty_d[scan_idx_q] =
                         merge_bytes(scan_qty_q[scan_idx_q], apb.PWDATA, apb.PSTRB);
        OFF_WBASE:     scan_wbase_d[scan_idx_q] =
                         merge_bytes(scan_wbase_q[scan_idx_q], apb.PWDATA, apb.PSTRB);
        OFF_RBASE:     scan_rbase_d[scan_idx_q] =
                         merge_bytes(scan_rbase_q[scan_idx_q], apb.PWDATA, apb.PSTRB);
        default: ;
      endcase
    end
    // Set conditions are applied after the clear so they win.
    irq_d = irq_d | {stat_tx_empty, rx_done};
  end

  // Read mux: combinational while selected
  always_comb begin
    apb.PRDATA = 32'd0;
    if (apb.PSEL && !apb.PWRITE) begin
      case (off)
        OFF_DO:        apb.PRDATA = do_q;
        OFF_DI:        apb.PRDATA = di_s2_q;
        OFF_TIMER:     apb.PRDATA = timer_q;
        OFF_MSG:       apb.PRDATA = {23'd0, rx_valid_q, rx_byte_q};
        OFF_CFG0:      apb.PRDATA = cfg0_q;
        OFF_CFG1:      apb.PRDATA = cfg1_q;
        OFF_MAP:       apb.PRDATA = map_q;
        OFF_IRQ:       apb.PRDATA = {30'd0, irq_q};
        OFF_SCAN_CTRL: apb.PRDATA = scan_ctrl_q;
        OFF_SCAN_IDX:  apb.PRDATA = {30'd0, scan_idx_q};
        OFF_ENTRY:     apb.PRDATA = scan_entry_q[scan_idx_q];
        OFF_QTY:       apb.PRDATA = scan_qty_q[scan_idx_q];
        OFF_WBASE:     apb.PRDATA = scan_wbase_q[scan_idx_q];
        OFF_RBASE:     apb.PRDATA = scan_rbase_q[scan_idx_q];
        default:       apb.PRDATA = 32'd0;
      endcase
    end
  end

  // TX: holding byte feeds the shifter whenever it is idle
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 20'd1;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    hold_byte_d = hold_byte_q;
    hold_full_d = hold_full_q;
    if (msg_wr && !hold_full_q) begin
      hold_byte_d = apb.PWDATA[7:0];
      hold_full_d = 1'b1;
    end
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = 20'd0;
        if (hold_full_q) begin
          tx_shift_d  = hold_byte_q;
          hold_full_d = 1'b0;
          tx_state_d  = ST_START;
        end
      end
      ST_START: if (tx_cnt_q == bit_last) begin
        tx_cnt_d   = 20'd0;
        tx_bit_d   = 3'd0;
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_cnt_q == bit_last) begin
        tx_cnt_d   = 20'd0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
      end
      ST_STOP: if (tx_cnt_q == bit_last) begin
        tx_cnt_d   = 20'd0;
        tx_state_d = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase
    // Line level follows the next state so it is glitch-free from a flop.
    case (tx_state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // RX: start bit re-checked at half-bit, then sampled at each bit centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 20'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = msg_rd ? 1'b0 : rx_valid_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = 20'd0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = ST_START;
      end
      ST_START: if (rx_cnt_q == half_last) begin
        rx_cnt_d   = 20'd0;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt_q == bit_last) begin
        rx_cnt_d   = 20'd0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_cnt_q == bit_last) begin
        rx_cnt_d   = 20'd0;
        rx_state_d = ST_IDLE;
        if (rx_s2_q) begin
          rx_byte_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_done    = 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      do_q        <= 32'd0;
      timer_q     <= 32'd0;
      cfg0_q      <= CFG0_RST;
      cfg1_q      <= CFG1_RST;
      map_q       <= 32'd0;
      scan_ctrl_q <= SCAN_CTRL_RST;
      scan_idx_q  <= 2'd0;
      irq_q       <= 2'b10;
      di_s1_q     <= 32'd0;
      di_s2_q     <= 32'd0;
      // NOTE: the scan table is tiny and has non-zero reset values, so it is
      // reset like ordinary flops rather than built as an unreset memory.
      for (int i = 0; i < 4; i++) begin
        scan_entry_q[i] <= ENTRY_RST;
        scan_qty_q[i]   <= QTY_RST;
        scan_wbase_q[i] <= 32'd0;
        scan_rbase_q[i] <= 32'd0;
      end
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= 20'd0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      tx_line_q   <= 1'b1;
      hold_byte_q <= 8'd0;
      hold_full_q <= 1'b0;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= 20'd0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      do_q         <= do_d;
      timer_q      <= timer_d;
      cfg0_q       <= cfg0_d;
      cfg1_q       <= cfg1_d;
      map_q        <= map_d;
      scan_ctrl_q  <= scan_ctrl_d;
      scan_idx_q   <= scan_idx_d;
      irq_q        <= irq_d;
      di_s1_q      <= GPIO_DI;
      di_s2_q      <= di_s1_q;
      scan_entry_q <= scan_entry_d;
      scan_qty_q   <= scan_qty_d;
      scan_wbase_q <= scan_wbase_d;
      scan_rbase_q <= scan_rbase_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      hold_byte_q  <= hold_byte_d;
      hold_full_q  <= hold_full_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_s1_q      <= UART_RX;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_modbus_converter.sv
// Scoreboard bench for modbus_converter: APB reads and UART frames push
// expectations; monitors pop and compare when the DUT presents data.
module tb_modbus_converter;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        uart_tx;
  logic        uart_rx;
  logic [31:0] gpio_di;
  logic [31:0] gpio_do;

  modbus_converter_if apb ();

  modbus_converter dut (
    .PCLK    (clk),
    .PRESETn (rst),
    .apb     (apb),
    .UART_RX (uart_rx),
    .UART_TX (uart_tx),
    .GPIO_DI (gpio_di),
    .GPIO_DO (gpio_do)
  );

  assign uart_rx = uart_tx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   frames_seen  = 0;
  exp_t rd_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] lo, input logic [31:0] hi);
    tests_run++;
    if ((^act === 1'bx) || act < lo || act > hi) begin
      tests_failed++;
      if (lo == hi)
        $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, lo);
      else
        $display("FAIL %s: got 0x%08h, expected 0x%08h..0x%08h", name, act, lo, hi);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s = 4'hF);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = a; apb.PWDATA = d; apb.PSTRB = s;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string name, input logic [11:0] a,
                          input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    e.name = name; e.lo = lo; e.hi = hi;
    rd_q.push_back(e);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] v);
    apb_read(name, a, v, v);
  endtask

  // APB monitor: compares read data and bus status on every access phase
  always @(negedge clk) begin
    if (!rst && apb.PSEL && apb.PENABLE) begin
      check("pready_pslverr", {30'd0, apb.PREADY, apb.PSLVERR}, 32'd2, 32'd2);
      if (!apb.PWRITE) begin
        if (rd_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_read: got 0x%08h, no expectation queued", apb.PRDATA);
        end else begin
          exp_t e;
          e = rd_q.pop_front();
          check(e.name, apb.PRDATA, e.lo, e.hi);
        end
      end
    end
  end

  // UART monitor: assumes divisor 1 (16 clocks per bit) while frames are sent
  initial begin
    logic [9:0] bits;
    forever begin
      @(negedge uart_tx);
      if (!rst) begin
        repeat (8) @(negedge clk);
        bits[0] = uart_tx;
        for (int i = 1; i < 10; i++) begin
          repeat (16) @(negedge clk);
          bits[i] = uart_tx;
        end
        if (tx_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_frame: got 0x%03h, no expectation queued", bits);
        end else begin
          logic [7:0] b;
          b = tx_q.pop_front();
          check("uart_frame", {22'd0, bits}, {22'd0, 1'b1, b, 1'b0}, {22'd0, 1'b1, b, 1'b0});
        end
        frames_seen++;
      end
    end
  end

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;
    gpio_di = 32'd0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1, 32'd1);
    check("reset_gpio_do", gpio_do, 32'd0, 32'd0);
    rst = 1'b0;

    rd("rst_do",        12'h000, 32'h0);
    rd("rst_di",        12'h004, 32'h0);
    apb_read("rst_timer", 12'h008, 32'd0, 32'd16);
    rd("rst_msg",       12'h00C, 32'h0);
    rd("rst_cfg0",      12'h010, 32'h0001_0000);
    rd("rst_cfg1",      12'h014, 32'h0080_0036);
    rd("rst_map",       12'h018, 32'h0);
    rd("rst_irq",       12'h01C, 32'h2);
    rd("rst_scan_ctrl", 12'h020, 32'h0001_0014);
    rd("rst_unmapped",  12'h024, 32'h0);
    rd("rst_scan_idx",  12'h028, 32'h0);
    rd("rst_entry",     12'h02C, 32'h0001_0400);
    rd("rst_qty",       12'h030, 32'h0010_0010);
    rd("rst_wbase",     12'h034, 32'h0);
    rd("rst_rbase",     12'h038, 32'h0);

    apb_write(12'h000, 32'hDEAD_BEEF);
    rd("do_full", 12'h000, 32'hDEAD_BEEF);
    check("gpio_do", gpio_do, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    apb_write(12'h000, 32'h1234_5678, 4'b0011);
    rd("do_strb", 12'h000, 32'hDEAD_5678);

    apb_write(12'h004, 32'hFFFF_FFFF);
    rd("di_ro", 12'h004, 32'h0);
    gpio_di = 32'hA5A5_5A5A;
    repeat (2) @(posedge clk);
    rd("di_sync", 12'h004, 32'hA5A5_5A5A);

    apb_write(12'h008, 32'h0000_00F0);
    apb_read("timer_load", 12'h008, 32'hF0, 32'hF3);
    repeat (10) @(posedge clk);
    apb_read("timer_runs", 12'h008, 32'hF4, 32'h120);

    apb_write(12'h01C, 32'hFFFF_FFFF);
    rd("irq_set_wins", 12'h01C, 32'h2);

    apb_write(12'h024, 32'hFFFF_FFFF);
    rd("unmapped_wr", 12'h024, 32'h0);

    apb_write(12'h010, 32'h0000_0105);
    apb_write(12'h014, 32'h0001_0020);
    apb_write(12'h018, 32'h0000_0044);
    rd("cfg0", 12'h010, 32'h0000_0105);
    rd("cfg1", 12'h014, 32'h0001_0020);
    rd("map",  12'h018, 32'h0000_0044);

    apb_write(12'h020, 32'h0000_0101);
    apb_write(12'h028, 32'h0000_0001);
    apb_write(12'h02C, 32'h0100_0302);
    apb_write(12'h030, 32'h0004_0002);
    apb_write(12'h034, 32'h0000_0020);
    apb_write(12'h038, 32'h0000_0030);
    rd("scan_ctrl", 12'h020, 32'h0000_0101);
    rd("scan_idx",  12'h028, 32'h1);
    rd("entry1",    12'h02C, 32'h0100_0302);
    rd("qty1",      12'h030, 32'h0004_0002);
    rd("wbase1",    12'h034, 32'h0000_0020);
    rd("rbase1",    12'h038, 32'h0000_0030);
    apb_write(12'h028, 32'h0000_0000);
    rd("entry0_untouched", 12'h02C, 32'h0001_0400);
    apb_write(12'h028, 32'hFFFF_FFFD);
    rd("scan_idx_mask", 12'h028, 32'h1);
    rd("entry1_again",  12'h02C, 32'h0100_0302);

    // Loopback frame at divisor 1
    apb_write(12'h014, 32'h0001_0001);
    tx_q.push_back(8'h55);
    apb_write(12'h00C, 32'h0000_0055);
    apb_write(12'h01C, 32'h0000_0002);
    rd("irq_cleared_busy", 12'h01C, 32'h0);
    for (int i = 0; i < 400 && frames_seen == 0; i++) @(posedge clk);
    check("frame_seen", frames_seen, 32'd1, 32'd1);
    repeat (20) @(posedge clk);
    rd("msg_rx",       12'h00C, 32'h155);
    rd("msg_rx_clear", 12'h00C, 32'h055);
    rd("irq_rx_done",  12'h01C, 32'h3);
    apb_write(12'h01C, 32'h0000_0001);
    rd("irq_w1c_rx",   12'h01C, 32'h2);

    repeat (4) @(posedge clk);
    check("reads_drained", rd_q.size(), 32'd0, 32'd0);
    check("frames_drained", tx_q.size(), 32'd0, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/modbus_converter.md
# modbus_converter

APB3-slave register block bridging a host CPU to GPIOs and a Modbus RTU serial link. It holds digital-output/input registers, a free-running timer, Modbus/UART configuration, an IRQ status register and a 4-entry scan table. It includes a minimal 8N1 UART byte transmitter and receiver. It sits on the peripheral bus as the PLC I/O converter.

## Interface
- No parameters.
- PCLK  in  1  single clock for all logic.
- PRESETn  in  1  asynchronous, active-high reset.
- PADDR  in  12  byte address; bits [5:2] decode, [1:0] ignored.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 controls.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte write strobes.
- PRDATA  out  32  read data.
- PREADY  out  1  constant 1; no wait states.
- PSLVERR  out  1  constant 0.
- UART_RX  in  1  serial input, idle high.
- UART_TX  out  1  serial output; reset value 1 (idle).
- GPIO_DI  in  32  digital inputs, asynchronous.
- GPIO_DO  out  32  equals the DO register; reset value 0.

## Operation
- A write occurs when PSEL & PENABLE & PWRITE. Byte lanes are gated by PSTRB on every RW register.
- Reads return data when PSEL & !PWRITE. Unmapped offsets, including 0x024, read 0 and ignore writes.
- 0x000 DO: RW, reset 0. Drives GPIO_DO.
- 0x004 DI: RO. Returns GPIO_DI through a 2-flop synchronizer; reset 0. Writes are ignored.
- 0x008 TIMER: RW 32-bit counter, reset 0, increments by 1 every PCLK and wraps modulo 2^32. A write loads the value, and counting resumes on the next cycle.
- 0x00C MSG: a write with PSTRB[0] loads PWDATA[7:0] into the TX holding byte if it is empty; otherwise the write is dropped. Read returns {23'b0, rx_valid, rx_byte}, reset 0. A read clears rx_valid.
- 0x010 CFG0: RW, reset 0x0001_0000. [7:0] unit ID, [8] converter enable; remaining bits are stored only.
- 0x014 CFG1: RW, reset 0x0080_0036.
  - [15:0] baud divisor D: one bit time = 16·D PCLKs. A value of 0 is treated as 1.
  - [31:16] frame-silence timeout in bit times; stored only.
- 0x018 MAP: RW base pointer, reset 0.
- 0x01C IRQ status, reset value 0x0000_0002.
  - bit0 rx_done: set on each received byte.
  - bit1 tx_empty: set every cycle that stat_tx_empty = 1.
  - Write-1-to-clear. A set condition in the same cycle wins over the clear. Other bits read 0.
- stat_tx_empty: internal net named exactly this; 1 when the TX holding byte is empty and the shifter is idle.
- 0x020 SCAN_CTRL: RW, reset 0x0001_0014. [0] scan enable, [15:8] poll period, [31:16] unit; stored only.
- 0x028 SCAN_IDX: RW, reset 0. Bits [1:0] select a table entry; upper bits read 0.
- 0x02C/0x030/0x034/0x038 SCAN_ENTRY/QTY/WBASE/RBASE: RW windows into entry[SCAN_IDX]. Reset values of every entry:
  - ENTRY 0x0001_0400
  - QTY 0x0010_0010
  - WBASE 0
  - RBASE 0
- UART TX: 8N1, LSB first. Loads the shifter from the holding byte when idle.
- UART RX: 2-flop synchronized. Detects the start bit on the falling edge and samples mid-bit.
  - Stop bit = 1: stores rx_byte, sets rx_valid and IRQ[0].
  - Stop bit = 0: byte discarded.

## Timing
- Zero-wait APB: PREADY = 1 always. Writes commit at the PCLK edge ending the access phase.
- PRDATA is combinational from the current registers during PSEL.
- DI latency: GPIO_DI change is visible within 2 PCLKs.
- TIMER readback right after a write of V returns between V and V+3.
- Reset takes effect immediately while PRESETn = 1.
  - All registers return to reset values.
  - UART state machines go to IDLE; UART_TX = 1.
- Reset mid-frame aborts the frame and drops the holding byte.
- TX states: IDLE → START → DATA×8 → STOP → IDLE; each state lasts 16·D clocks.
- RX states: same sequence; the start bit is re-checked at its half-bit point.

## Test plan
- Reset, then read every register:
  - DO/DI/MSG/MAP/SCAN_IDX/WBASE/RBASE read 0; TIMER ≤ 16.
  - CFG0 0x0001_0000, CFG1 0x0080_0036, IRQ 0x2.
  - SCAN_CTRL 0x0001_0014, ENTRY 0x0001_0400, QTY 0x0010_0010.
- DO:
  - Write 0xDEADBEEF → read 0xDEADBEEF.
  - Then write 0x12345678 with PSTRB = 0011 → read 0xDEAD5678.
- DI:
  - Write 0xFFFFFFFF to 0x004 → read 0.
  - Drive GPIO_DI = 0xA5A55A5A, wait 2 clocks → read 0xA5A55A5A.
- TIMER:
  - Write 0xF0 → read within 0xF0..0xF3.
  - 10 clocks later the value is strictly greater.
- IRQ:
  - Write 0xFFFFFFFF → read 0x2.
  - Force stat_tx_empty = 0, write 0x2 → read 0.
- CFG/MAP/scan:
  - Write CFG0 0x105, CFG1 0x00010020, MAP 0x44 → same values read back.
  - SCAN_CTRL 0x101; IDX 1; ENTRY 0x01000302; QTY 0x00040002; WBASE 0x20; RBASE 0x30 → same values read back.
  - PSLVERR stays 0 throughout.
  - Writing MSG = 0x55 with D = 1 produces a 10-bit frame on UART_TX, 16 clocks per bit. Looping it back to UART_RX gives MSG read 0x155 and IRQ[0] = 1.
